// File: rtl/move_key_tx_if.sv
// Byte-transmit handshake between the movement-key controller and the shared uart core.
// The controller drives transmit/tx_byte; the uart core reports is_transmitting.
interface move_key_tx_if;
   logic       transmit;
   logic [7:0] tx_byte;
   logic       is_transmitting;

   modport master (output transmit, output tx_byte, input is_transmitting);
   modport slave  (input transmit, input tx_byte, output is_transmitting);
endinterface

// File: rtl/move_key_tx.sv
// Debounces jump/left/right buttons and sends 'w'/'a'/'d' key bytes through the uart core,
// auto-repeating while a button is held so far-end hold timers keep running.
module move_key_tx #(
   parameter int INIT_DELAY      = 100_000,
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int REPEAT_CYCLES   = 20_000_000
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                btn_up,
   input  logic                btn_left,
   input  logic                btn_right,
   move_key_tx_if.master       uart,
   output logic                busy,
   output logic [7:0]          sent_count
);

   localparam int IW = $clog2(INIT_DELAY) + 1;
   localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam int RW = $clog2(REPEAT_CYCLES) + 1;
   localparam logic [IW-1:0] INIT_MAX = IW'(INIT_DELAY - 1);
   localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RW-1:0] REP_MAX  = RW'(REPEAT_CYCLES - 1);

   typedef enum logic [1:0] {S_INIT, S_IDLE, S_SEND, S_DONE} state_t;

   state_t        state, state_nxt;
   logic [2:0]    raw, sync1, sync2, deb, deb_q, ev, pending, pick;
   logic [7:0]    pick_byte;
   logic [DW-1:0] deb_cnt [3];
   logic [RW-1:0] rep_cnt [3];
   logic [IW-1:0] init_cnt;

   // Bit 0 = up, 1 = left, 2 = right; lower index wins arbitration.
   assign raw = {btn_right, btn_left, btn_up};

   // NOTE: sequential state uses <= so every flop samples pre-edge values, independent of
   // statement order; the small per-button counter arrays are reset like any other register.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync1 <= '0;
         sync2 <= '0;
         deb   <= '0;
         deb_q <= '0;
         for (int i = 0; i < 3; i++) begin
            deb_cnt[i] <= '0;
            rep_cnt[i] <= '0;
         end
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         deb_q <= deb;
         for (int i = 0; i < 3; i++) begin
            if (sync2[i] != deb[i]) begin
               if (deb_cnt[i] == DEB_MAX) begin
                  deb[i]     <= sync2[i];
                  deb_cnt[i] <= '0;
               end else begin
                  deb_cnt[i] <= deb_cnt[i] + DW'(1);
               end
            end else begin
               deb_cnt[i] <= '0;
            end

            if (!deb[i])                  rep_cnt[i] <= '0;
            else if (rep_cnt[i] == REP_MAX) rep_cnt[i] <= '0;
            else                          rep_cnt[i] <= rep_cnt[i] + RW'(1);
         end
      end
   end

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      ev = '0;
      for (int i = 0; i < 3; i++)
         ev[i] = deb[i] & (~deb_q[i] | (rep_cnt[i] == REP_MAX));
   end

   always_comb begin
      pick      = '0;
      pick_byte = 8'h00;
      if (pending[0])      begin pick = 3'b001; pick_byte = 8'h77; end
      else if (pending[1]) begin pick = 3'b010; pick_byte = 8'h61; end
      else if (pending[2]) begin pick = 3'b100; pick_byte = 8'h64; end
   end

   // Events arriving on the pickup edge are OR-ed in after the clear, so they stay queued.
   always_ff @(posedge clk) begin
      if (!reset_n || state == S_INIT) pending <= '0;
      else if (state == S_IDLE)        pending <= (pending & ~pick) | ev;
      else                             pending <= pending | ev;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) state <= S_INIT;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_INIT: if (init_cnt == INIT_MAX)     state_nxt = S_IDLE;
         S_IDLE: if (|pending)                 state_nxt = S_SEND;
         S_SEND: if (uart.is_transmitting)     state_nxt = S_DONE;
         S_DONE: if (!uart.is_transmitting)    state_nxt = S_IDLE;
         default:                              state_nxt = S_INIT;
      endcase
   end

   always_comb begin
      uart.transmit = (state == S_SEND) & ~uart.is_transmitting;
      busy          = (state != S_IDLE);
   end

   // tx_byte only changes in S_IDLE, holding the byte steady through the whole frame.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         init_cnt     <= '0;
         uart.tx_byte <= 8'h00;
         sent_count   <= 8'h00;
      end else begin
         if (state == S_INIT)
            init_cnt <= (init_cnt == INIT_MAX) ? '0 : init_cnt + IW'(1);
         if (state == S_IDLE)
            uart.tx_byte <= pick_byte;
         if (state == S_SEND && uart.is_transmitting)
            sent_count <= sent_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_move_key_tx.sv
// Directed bench for move_key_tx with a simple uart model: is_transmitting rises one cycle
// after transmit and stays high 20 cycles; each frame start logs its byte and cycle.
module tb_move_key_tx;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       btn_up, btn_left, btn_right;
   logic       busy;
   logic [7:0] sent_count;
   int         checks   = 0;
   int         failures = 0;
   int         cycle    = 0;
   int         hold     = 0;
   logic [7:0] byte_q [$];
   int         stamp_q [$];
   logic [14:0] bounce;

   move_key_tx_if u_if ();

   move_key_tx #(
      .INIT_DELAY      (10),
      .DEBOUNCE_CYCLES (4),
      .REPEAT_CYCLES   (60)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .btn_up     (btn_up),
      .btn_left   (btn_left),
      .btn_right  (btn_right),
      .uart       (u_if),
      .busy       (busy),
      .sent_count (sent_count)
   );

   always #5 clk = ~clk;

   initial u_if.is_transmitting = 1'b0;

   always @(posedge clk) begin
      cycle <= cycle + 1;
      if (hold > 0) begin
         hold <= hold - 1;
         if (hold == 1) u_if.is_transmitting <= 1'b0;
      end else if (u_if.transmit && !u_if.is_transmitting) begin
         u_if.is_transmitting <= 1'b1;
         hold <= 20;
         byte_q.push_back(u_if.tx_byte);
         stamp_q.push_back(cycle);
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] qb(input int i);
      return (i < byte_q.size()) ? byte_q[i] : 8'hxx;
   endfunction

   function automatic int gap(input int i);
      return (i < stamp_q.size()) ? stamp_q[i] - stamp_q[i-1] : -1;
   endfunction

   task automatic clear_log();
      byte_q.delete();
      stamp_q.delete();
   endtask

   initial begin
      reset_n = 1'b0;
      btn_up = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
      cyc(3);
      check("rst_transmit", 32'(u_if.transmit), 0);
      check("rst_tx_byte",  32'(u_if.tx_byte), 0);
      check("rst_busy",     32'(busy), 1);
      check("rst_count",    32'(sent_count), 0);

      // Press during S_INIT: debounced rise is discarded, busy drops exactly at cycle 10.
      reset_n = 1'b1;
      btn_up  = 1'b1;
      cyc(8);
      btn_up = 1'b0;
      cyc(1);
      check("init_busy_c9", 32'(busy), 1);
      cyc(1);
      check("init_busy_c10", 32'(busy), 0);
      cyc(30);
      check("init_no_bytes", 32'(byte_q.size()), 0);
      check("init_count",    32'(sent_count), 0);

      // Single press: transmit rises 2 sync + 4 debounce + 1 pending + 1 FSM cycles later.
      clear_log();
      btn_up = 1'b1;
      cyc(7);
      check("up_tx_early", 32'(u_if.transmit), 0);
      cyc(1);
      check("up_tx_high",  32'(u_if.transmit), 1);
      check("up_tx_byte",  32'(u_if.tx_byte), 32'h77);
      cyc(2);
      btn_up = 1'b0;
      cyc(40);
      check("up_nbytes", 32'(byte_q.size()), 1);
      check("up_byte0",  32'(qb(0)), 32'h77);
      check("up_count",  32'(sent_count), 1);
      check("up_idle",   32'(busy), 0);

      // Bouncing left button (runs of at most 3) then steady: one byte only.
      clear_log();
      bounce = 15'b011_0100_1110_1101;
      for (int i = 0; i < 15; i++) begin
         btn_left = bounce[i];
         cyc(1);
      end
      btn_left = 1'b1;
      cyc(20);
      btn_left = 1'b0;
      cyc(40);
      check("left_nbytes", 32'(byte_q.size()), 1);
      check("left_byte0",  32'(qb(0)), 32'h61);
      check("left_count",  32'(sent_count), 2);

      // Held right button: press byte plus repeats every 60 cycles, none after release.
      clear_log();
      btn_right = 1'b1;
      cyc(200);
      btn_right = 1'b0;
      cyc(80);
      check("right_nbytes", 32'(byte_q.size()), 4);
      for (int i = 0; i < 4; i++) check($sformatf("right_byte%0d", i), 32'(qb(i)), 32'h64);
      check("right_gap2",  32'(gap(2)), 60);
      check("right_gap3",  32'(gap(3)), 60);
      check("right_count", 32'(sent_count), 6);

      // Simultaneous presses: priority order, back-to-back frames 23 cycles apart.
      clear_log();
      btn_up = 1'b1; btn_left = 1'b1; btn_right = 1'b1;
      cyc(10);
      btn_up = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
      cyc(100);
      check("all_nbytes", 32'(byte_q.size()), 3);
      check("all_byte0",  32'(qb(0)), 32'h77);
      check("all_byte1",  32'(qb(1)), 32'h61);
      check("all_byte2",  32'(qb(2)), 32'h64);
      check("all_gap1",   32'(gap(1)), 23);
      check("all_gap2",   32'(gap(2)), 23);
      check("all_count",  32'(sent_count), 9);

      // Reset while in S_DONE, button still held: only the repeat path resends after INIT.
      clear_log();
      btn_up = 1'b1;
      cyc(15);
      check("done_busy",  32'(busy), 1);
      check("done_byte",  32'(u_if.tx_byte), 32'h77);
      check("done_count", 32'(sent_count), 10);
      reset_n = 1'b0;
      cyc(1);
      check("mid_rst_transmit", 32'(u_if.transmit), 0);
      check("mid_rst_tx_byte",  32'(u_if.tx_byte), 0);
      check("mid_rst_count",    32'(sent_count), 0);
      check("mid_rst_busy",     32'(busy), 1);
      reset_n = 1'b1;
      clear_log();
      cyc(50);
      check("post_rst_quiet", 32'(byte_q.size()), 0);
      cyc(40);
      check("post_rst_nbytes", 32'(byte_q.size()), 1);
      check("post_rst_byte0",  32'(qb(0)), 32'h77);
      check("post_rst_count",  32'(sent_count), 1);
      btn_up = 1'b0;
      cyc(30);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
